// File: rtl/reaction_timer_multi.sv
// -----------------------------------------------------------------------------
// reaction_timer_multi
//
// Multi-player reaction timer. A host Start launches a round: after a random
// delay (RandomValue ms, zero treated as one) the stimulus LED lights and each
// player's first button press is timed in milliseconds. A press during the
// delay marks the player as a cheat and removes them from the round. Players
// who do not respond within TIMEOUT_MS are given TIMEOUT_MS and raise Slow.
// Results are offered to a display with LCDUpdate until LCDAck, then held
// until the next Start.
//
// Ports:
//   Clk          : sole clock, rising edge
//   Rst          : synchronous active-high reset
//   Start        : start a round / acknowledge shown results (IDLE, SHOW)
//   Press        : player buttons, synchronous level inputs
//   RandomValue  : pre-stimulus delay in ms
//   LCDAck       : display has taken the results
//   LED          : stimulus lamp, all ones while timing
//   Wait         : delay phase active
//   Slow         : at least one player timed out
//   Cheat        : per-player early press, sticky for the round
//   ReactionTime : player i at bits [i*TIME_W +: TIME_W]
//   Winner       : one-hot fastest valid player, zero if none
//   LCDUpdate    : results ready for display
// -----------------------------------------------------------------------------
module reaction_timer_multi #(
   parameter int N_PLAYERS   = 2,
   parameter int TIME_W      = 10,
   parameter int RAND_W      = 13,
   parameter int CLKS_PER_MS = 1000,
   parameter int TIMEOUT_MS  = 500,
   parameter int LED_W       = 8
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic                          Start,
   input  logic [N_PLAYERS-1:0]          Press,
   input  logic [RAND_W-1:0]             RandomValue,
   input  logic                          LCDAck,
   output logic [LED_W-1:0]              LED,
   output logic                          Wait,
   output logic                          Slow,
   output logic [N_PLAYERS-1:0]          Cheat,
   output logic [N_PLAYERS*TIME_W-1:0]   ReactionTime,
   output logic [N_PLAYERS-1:0]          Winner,
   output logic                          LCDUpdate
);

   localparam int                 PRE_W   = $clog2(CLKS_PER_MS);
   localparam logic [PRE_W-1:0]   PRE_MAX = PRE_W'(CLKS_PER_MS - 1);
   localparam logic [TIME_W-1:0]  TO_VAL  = TIME_W'(TIMEOUT_MS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DELAY,
      S_ARMED,
      S_REPORT,
      S_SHOW
   } state_t;

   state_t                        state_q, state_d;
   logic [PRE_W-1:0]              presc_q, presc_d;
   logic [RAND_W-1:0]             delay_q, delay_d;
   logic [TIME_W-1:0]             elapsed_q, elapsed_d;
   logic [N_PLAYERS-1:0]          press_q;
   logic [N_PLAYERS-1:0]          done_q, done_d;
   logic [N_PLAYERS-1:0]          disq_q, disq_d;
   logic [N_PLAYERS-1:0]          cheat_q, cheat_d;
   logic [N_PLAYERS-1:0]          winner_q, winner_d;
   logic [N_PLAYERS*TIME_W-1:0]   rt_q, rt_d;
   logic                          slow_q, slow_d;
   logic [LED_W-1:0]              led_q;
   logic                          wait_q;
   logic                          lcd_q;

   logic                          tick;
   logic [N_PLAYERS-1:0]          press_edge;
   logic [N_PLAYERS-1:0]          capture;
   logic [N_PLAYERS-1:0]          pending;

   always_comb begin
      tick       = (presc_q == PRE_MAX);
      press_edge = Press & ~press_q;
      capture    = '0;
      pending    = '0;

      state_d    = state_q;
      presc_d    = tick ? '0 : presc_q + 1'b1;
      delay_d    = delay_q;
      elapsed_d  = elapsed_q;
      done_d     = done_q;
      disq_d     = disq_q;
      cheat_d    = cheat_q;
      winner_d   = winner_q;
      rt_d       = rt_q;
      slow_d     = slow_q;

      case (state_q)
         S_IDLE, S_SHOW: begin
            if (Start) begin
               state_d   = S_DELAY;
               presc_d   = '0;
               delay_d   = (RandomValue == '0) ? RAND_W'(1) : RandomValue;
               elapsed_d = '0;
               done_d    = '0;
               disq_d    = '0;
               cheat_d   = '0;
               winner_d  = '0;
               rt_d      = '0;
               slow_d    = 1'b0;
            end
         end

         S_DELAY: begin
            cheat_d = cheat_q | press_edge;
            disq_d  = disq_q | press_edge;
            // Everyone jumped the gun: nothing left to time.
            if (&disq_d) begin
               state_d = S_REPORT;
            end else if (tick) begin
               delay_d = delay_q - 1'b1;
               if (delay_q == RAND_W'(1)) begin
                  state_d   = S_ARMED;
                  presc_d   = '0;
                  elapsed_d = '0;
               end
            end
         end

         S_ARMED: begin
            if (tick) begin
               elapsed_d = elapsed_q + 1'b1;
            end
            capture = press_edge & ~disq_q & ~done_q;
            done_d  = done_q | capture;
            for (int i = 0; i < N_PLAYERS; i++) begin
               if (capture[i]) begin
                  rt_d[i*TIME_W +: TIME_W] = elapsed_q;
               end
            end
            // Isolate the lowest set bit so simultaneous captures pick the
            // lowest player index.
            if ((winner_q == '0) && (capture != '0)) begin
               winner_d = capture & (~capture + 1'b1);
            end
            pending = ~done_d & ~disq_q;
            // A capture on the timeout cycle has already cleared its pending
            // bit, so it keeps its captured value.
            if (elapsed_q == TO_VAL) begin
               for (int i = 0; i < N_PLAYERS; i++) begin
                  if (pending[i]) begin
                     rt_d[i*TIME_W +: TIME_W] = TO_VAL;
                  end
               end
               slow_d  = |pending;
               state_d = S_REPORT;
            end else if (pending == '0) begin
               state_d = S_REPORT;
            end
         end

         S_REPORT: begin
            if (LCDAck) begin
               state_d = S_SHOW;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= S_IDLE;
         presc_q   <= '0;
         delay_q   <= '0;
         elapsed_q <= '0;
         // All ones so a button held through reset is not seen as an edge.
         press_q   <= '1;
         done_q    <= '0;
         disq_q    <= '0;
         cheat_q   <= '0;
         winner_q  <= '0;
         rt_q      <= '0;
         slow_q    <= 1'b0;
         led_q     <= '0;
         wait_q    <= 1'b0;
         lcd_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         delay_q   <= delay_d;
         elapsed_q <= elapsed_d;
         press_q   <= Press;
         done_q    <= done_d;
         disq_q    <= disq_d;
         cheat_q   <= cheat_d;
         winner_q  <= winner_d;
         rt_q      <= rt_d;
         slow_q    <= slow_d;
         // Phase outputs are decoded from the next state so they change on
         // the same edge as the state register.
         led_q     <= (state_d == S_ARMED) ? '1 : '0;
         wait_q    <= (state_d == S_DELAY);
         lcd_q     <= (state_d == S_REPORT);
      end
   end

   assign LED          = led_q;
   assign Wait         = wait_q;
   assign Slow         = slow_q;
   assign Cheat        = cheat_q;
   assign ReactionTime = rt_q;
   assign Winner       = winner_q;
   assign LCDUpdate    = lcd_q;

endmodule

// File: doc/reaction_timer_multi.md
REACTION_TIMER_MULTI -- requirements
Module: reaction_timer_multi

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N_PLAYERS, 2, number of player buttons (1..8)
- TIME_W, 10, reaction-time width in ms
- RAND_W, 13, random-delay width in ms
- CLKS_PER_MS, 1000, Clk cycles per ms tick (>=2)
- TIMEOUT_MS, 500, max reaction time in ms (< 2^TIME_W)
- LED_W, 8, stimulus LED width
REQ-002 Ports (name, direction, width, meaning), one per line:
- Clk, in, 1, sole clock, all logic on rising edge
- Rst, in, 1, synchronous active-high reset
- Start, in, 1, host start / result acknowledge
- Press, in, N_PLAYERS, player buttons, synchronous, level
- RandomValue, in, RAND_W, pre-stimulus delay in ms
- LCDAck, in, 1, display accepted results
- LED, out, LED_W, stimulus lamp
- Wait, out, 1, delay phase active
- Slow, out, 1, at least one player timed out
- Cheat, out, N_PLAYERS, per-player early press, sticky per round
- ReactionTime, out, N_PLAYERS*TIME_W, player i at bits [i*TIME_W +: TIME_W]
- Winner, out, N_PLAYERS, one-hot fastest valid player, zero if none
- LCDUpdate, out, 1, results ready for display

Function
REQ-003 FSM states: IDLE, DELAY, ARMED, REPORT, SHOW; all outputs registered.
REQ-004 Ms prescaler counts 0..CLKS_PER_MS-1 and clears on entry to DELAY and ARMED; first tick occurs exactly CLKS_PER_MS cycles after entry.
REQ-005 Press edge = Press & ~Press_q; Press_q resets to all-ones so a button held through reset produces no edge.
REQ-006 IDLE or SHOW with Start=1 -> DELAY next cycle; load delay counter from RandomValue (0 treated as 1); clear Cheat, Winner, Slow, all ReactionTime, done/disqualified masks.
REQ-007 DELAY: Wait=1, LED=0; delay counter decrements per tick; entry to ARMED on the tick where the counter reaches 0.
REQ-008 DELAY: a press edge from player i sets Cheat[i]=1 and disqualifies player i for the round.
REQ-009 DELAY: if all players are disqualified -> REPORT next cycle, Winner=0, ReactionTime untouched (0).
REQ-010 ARMED: LED all ones, Wait=0; elapsed-ms counter starts at 0 and increments per tick.
REQ-011 ARMED: the first press edge of each qualified player captures the current elapsed-ms value into ReactionTime[i]; later edges from that player are ignored.
REQ-012 ARMED: if Winner==0, the first capturing cycle sets Winner; simultaneous captures resolve to the lowest index.
REQ-013 ARMED: all qualified players captured -> REPORT next cycle.
REQ-014 ARMED: elapsed reaches TIMEOUT_MS -> each uncaptured qualified player gets ReactionTime=TIMEOUT_MS, Slow=1, REPORT next cycle; a capture in the same cycle takes priority for that player.
REQ-015 REPORT: LED=0, LCDUpdate=1; on a cycle with LCDAck=1 -> SHOW, LCDUpdate=0 next cycle; LCDAck high before REPORT has no effect.
REQ-016 SHOW: results held stable until Start.
REQ-017 Start is ignored in DELAY, ARMED and REPORT; Press is ignored in IDLE, REPORT and SHOW.

Reset
REQ-018 Rst=1 at any edge -> IDLE; LED, Wait, Slow, Cheat, Winner, LCDUpdate, ReactionTime = 0; prescaler, delay and elapsed counters = 0; Press_q all ones. Rst overrides all other inputs, including mid-round.

Verification (CLKS_PER_MS=10, N_PLAYERS=2, TIMEOUT_MS=50)
REQ-019 RandomValue=3, Start, no presses -> LED on 30 cycles after DELAY entry; Slow=1, both ReactionTime=50, Winner=00, LCDUpdate until LCDAck.
REQ-020 RandomValue=5, player 1 presses 20 cycles into DELAY, player 0 presses 75 cycles after LED on -> Cheat=10, ReactionTime0=7, Winner=01, Slow=0.
REQ-021 Both players press in the same cycle 42 cycles after LED on -> both ReactionTime=4, Winner=01.
REQ-022 Both players press during DELAY -> REPORT with Cheat=11, Winner=00, LED never lit.
REQ-023 Rst asserted mid-ARMED with Press held through reset -> all outputs 0; next round shows no spurious capture until Press is released and pressed again.
REQ-024 RandomValue=0 -> LED on after 10 cycles; Start in SHOW starts a new round with cleared results.
